// File: rtl/ospfb_frame_capture_pkg.sv
// Shared constants and types for the OSPFB output frame capture stage.
// Holds the default OSPFB geometry (FFT_LEN, SAMP_PER_CLK) and the capture data types.
package ospfb_frame_capture_pkg;

  localparam int unsigned SAMP_PER_CLK = 2;
  localparam int unsigned SAMP_WIDTH   = 32;
  localparam int unsigned FFT_LEN      = 2048;
  localparam int unsigned FRAMES       = 32;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CAPTURE,
    FULL
  } capture_state_t;

  typedef logic [SAMP_WIDTH-1:0]         capture_sample_t;
  typedef capture_sample_t [SAMP_PER_CLK-1:0] capture_beat_t;

  // Counter width helper that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ospfb_frame_capture_sdp_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Read-first: a read of the address being written returns the previous contents.
module ospfb_frame_capture_sdp_ram #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port; storage is not reset so captured data survives aborts and resets.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, always enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ospfb_frame_capture.sv
// AXI-Stream capture of FRAMES frame-aligned OSPFB output frames into on-chip RAM.
// Optional macro OSPFB_CAPTURE_BACKPRESSURE_EN: tready only in SYNC/CAPTURE;
// otherwise tready is tied high and beats outside SYNC/CAPTURE are dropped.
module ospfb_frame_capture
  import ospfb_frame_capture_pkg::*;
#(
  parameter int unsigned SAMP_PER_CLK = ospfb_frame_capture_pkg::SAMP_PER_CLK,
  parameter int unsigned SAMP_WIDTH   = ospfb_frame_capture_pkg::SAMP_WIDTH,
  parameter int unsigned FFT_LEN      = ospfb_frame_capture_pkg::FFT_LEN,
  parameter int unsigned FRAMES       = ospfb_frame_capture_pkg::FRAMES,
  parameter int unsigned BEATS        = FFT_LEN / SAMP_PER_CLK,
  parameter int unsigned DEPTH        = FRAMES * BEATS,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned DW           = SAMP_PER_CLK * SAMP_WIDTH,
  parameter int unsigned FCW          = $clog2(FRAMES + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [DW-1:0]  s_axis_tdata,
  input  logic           s_axis_tvalid,
  input  logic           s_axis_tlast,
  output logic           s_axis_tready,
  output logic           full,
  output logic [FCW-1:0] frame_cnt,
  output logic           err_tlast_early,
  output logic           err_tlast_missing,
  input  logic [AW-1:0]  rd_addr,
  output logic [DW-1:0]  rd_data
);

  localparam int unsigned BW = cnt_width(BEATS);

  capture_state_t state;
  capture_state_t state_next;

  logic          accept;
  logic          wr_en;
  logic          beat_last;
  logic          addr_last;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] beat_cnt;

`ifdef OSPFB_CAPTURE_BACKPRESSURE_EN
  assign s_axis_tready = (state == SYNC) || (state == CAPTURE);
`else
  assign s_axis_tready = 1'b1;
`endif

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign beat_last = (beat_cnt == BW'(BEATS - 1));
  assign addr_last = (wr_addr == AW'(DEPTH - 1));
  assign full      = (state == FULL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and write-enable decode; dropping en aborts SYNC/CAPTURE.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_next = SYNC;
      end
      SYNC: begin
        if (!en) begin
          state_next = IDLE;
        end else if (accept && s_axis_tlast) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        // An accept in the abort cycle is still stored.
        wr_en = accept;
        if (!en) begin
          state_next = IDLE;
        end else if (accept && addr_last) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (!en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address, beat/frame counters and sticky alignment flags; cleared whenever heading to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr           <= '0;
      beat_cnt          <= '0;
      frame_cnt         <= '0;
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
    end else if (state_next == IDLE) begin
      wr_addr           <= '0;
      beat_cnt          <= '0;
      frame_cnt         <= '0;
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
    end else if (wr_en) begin
      wr_addr <= wr_addr + 1'b1;
      // Framing follows beat_cnt only; tlast never resynchronises it.
      if (beat_last) begin
        beat_cnt  <= '0;
        frame_cnt <= frame_cnt + 1'b1;
        if (!s_axis_tlast) err_tlast_missing <= 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        if (s_axis_tlast) err_tlast_early <= 1'b1;
      end
    end
  end

  ospfb_frame_capture_sdp_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ospfb_frame_capture.sv
// Testbench for ospfb_frame_capture: randomized streams against a frame-level model,
// readback checked through a scoreboard queue by an independent monitor.
module tb_ospfb_frame_capture;

  localparam int unsigned SPC   = 2;
  localparam int unsigned SW    = 32;
  localparam int unsigned FL    = 16;
  localparam int unsigned FR    = 2;
  localparam int unsigned BEATS = FL / SPC;
  localparam int unsigned DEPTH = FR * BEATS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DW    = SPC * SW;
  localparam int unsigned FCW   = $clog2(FR + 1);

`ifdef OSPFB_CAPTURE_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast = 1'b0;
  logic           s_axis_tready;
  logic           full;
  logic [FCW-1:0] frame_cnt;
  logic           err_tlast_early;
  logic           err_tlast_missing;
  logic [AW-1:0]  rd_addr = '0;
  logic [DW-1:0]  rd_data;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  // Expected RAM image, updated only when the model says a beat is stored.
  logic [DW-1:0] model_mem [DEPTH];

  typedef struct {
    logic [DW-1:0] data;
    int            addr;
    int unsigned   cyc;
  } rd_exp_t;
  rd_exp_t rd_q[$];
  rd_exp_t rd_e;

  ospfb_frame_capture #(
    .SAMP_PER_CLK (SPC),
    .SAMP_WIDTH   (SW),
    .FFT_LEN      (FL),
    .FRAMES       (FR)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en                (en),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .full              (full),
    .frame_cnt         (frame_cnt),
    .err_tlast_early   (err_tlast_early),
    .err_tlast_missing (err_tlast_missing),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Readback monitor: rd_data is due one cycle after the address was issued.
  always @(negedge clk) begin
    if (rd_q.size() > 0) begin
      if (rd_q[0].cyc + 1 == cyc) begin
        rd_e = rd_q.pop_front();
        checks++;
        if (rd_data !== rd_e.data) begin
          failures++;
          $display("FAIL rd_data[%0d] actual=%h required=%h", rd_e.addr, rd_data, rd_e.data);
        end
      end else if (rd_q[0].cyc + 1 < cyc) begin
        rd_e = rd_q.pop_front();
        checks++;
        failures++;
        $display("FAIL rd_stale[%0d] actual=missed required=sampled", rd_e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] beat(input int v);
    logic [31:0] a;
    a = 32'(v);
    return {a ^ 32'h5A5A_0000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input bit chk_rd);
    chk({tag, ".tready"}, 64'(s_axis_tready), 64'(!BP));
    chk({tag, ".full"}, 64'(full), 64'd0);
    chk({tag, ".frame_cnt"}, 64'(frame_cnt), 64'd0);
    chk({tag, ".err_early"}, 64'(err_tlast_early), 64'd0);
    chk({tag, ".err_missing"}, 64'(err_tlast_missing), 64'd0);
    if (chk_rd) chk({tag, ".rd_data"}, 64'(rd_data), 64'd0);
  endtask

  // ph: 1 hunting for frame end, 2 storing, 3 all DEPTH beats stored.
  task automatic chk_status(input string tag, input int ph, input int k, input bit ee, input bit em);
    chk({tag, ".tready"}, 64'(s_axis_tready), 64'((ph == 1 || ph == 2) ? 1'b1 : !BP));
    chk({tag, ".full"}, 64'(full), 64'(ph == 3));
    chk({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(k / int'(BEATS)));
    chk({tag, ".err_early"}, 64'(err_tlast_early), 64'(ee));
    chk({tag, ".err_missing"}, 64'(err_tlast_missing), 64'(em));
  endtask

  // Arms the capture and streams beats carrying data base+idx; tlast every BEATS indices.
  task automatic run_stream(input string tag, input int first_idx, input int base, input int gap_pct,
                            input int early_idx, input int missing_idx, input int abort_at,
                            input int rst_at, input int post_beats);
    int idx, k, ph, post, budget;
    bit ee, em, valid, tl;
    logic [DW-1:0] d;
    idx = first_idx; k = 0; post = 0; budget = 0; ee = 0; em = 0;
    en = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ph = 1;
    while (budget < 400) begin
      budget++;
      chk_status(tag, ph, k, ee, em);
      if (ph == 3 && post >= post_beats) break;
      d  = beat(base + idx);
      tl = (((idx % int'(BEATS)) == int'(BEATS) - 1) && idx != missing_idx) || idx == early_idx;
      if (ph == 2 && k == abort_at) begin
        en = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = d;
        s_axis_tlast = tl;
        @(posedge clk);
        model_mem[k] = d;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk_idle({tag, ".abort"}, 1'b0);
        return;
      end
      if (ph == 2 && k == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_idle({tag, ".rst_async"}, 1'b1);
        en = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle({tag, ".rst_held"}, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle({tag, ".rst_rel"}, 1'b0);
        return;
      end
      valid = ($urandom_range(99) >= gap_pct) || ph == 3;
      s_axis_tvalid = valid;
      s_axis_tdata = d;
      s_axis_tlast = tl;
      @(posedge clk);
      if (valid) begin
        idx++;
        case (ph)
          1: if (tl) ph = 2;
          2: begin
            if (k % int'(BEATS) == int'(BEATS) - 1) begin
              if (!tl) em = 1'b1;
            end else if (tl) begin
              ee = 1'b1;
            end
            model_mem[k] = d;
            k++;
            if (k == int'(DEPTH)) ph = 3;
          end
          default: post++;
        endcase
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    if (budget >= 400) chk({tag, ".budget"}, 64'd1, 64'd0);
  endtask

  task automatic readback();
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_addr = AW'(a);
      rd_q.push_back('{data: model_mem[a], addr: a, cyc: cyc});
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_en(input string tag);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle(tag, 1'b0);
  endtask

  initial begin
    #1 chk_idle("reset", 1'b1);
    repeat (2) @(negedge clk);
    chk_idle("reset_hold", 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle", 1'b0);

    // Aligned stream, no gaps; extra beats after full must not land in RAM.
    run_stream("t1", 4, 0, 0, -1, -1, -1, -1, 4);
    readback();
    release_en("t1.rel");

    // Same stream with ~30% tvalid gaps.
    run_stream("t2", 4, 0, 30, -1, -1, -1, -1, 3);
    readback();
    release_en("t2.rel");

    // Early tlast on captured beat 4 of frame 0.
    run_stream("t3", 4, 0, 10, 12, -1, -1, -1, 2);
    readback();
    release_en("t3.rel");

    // Missing tlast on last beat of frame 0.
    run_stream("t4", 2, 50, 20, -1, 15, -1, -1, 2);
    readback();
    release_en("t4.rel");

    // Abort after 5 captured beats, then re-arm with fresh data.
    run_stream("t5", 4, 200, 0, -1, -1, 5, -1, 0);
    readback();
    @(negedge clk);
    run_stream("t6", 3, 300, 20, -1, -1, -1, -1, 3);
    readback();
    release_en("t6.rel");

    // Asynchronous reset mid-capture; RAM contents are retained.
    run_stream("t7", 4, 400, 15, -1, -1, -1, 9, 0);
    readback();

    if (rd_q.size() != 0) chk("rd_q_drain", 64'(rd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ospfb_frame_capture.md
# ospfb_frame_capture

Single-clock AXI-Stream capture stage that sits directly downstream of the OSPFB output and stores a fixed number of aligned output frames into on-chip RAM. Replaces the behavioural VIP capture model with synthesizable RTL usable on hardware and in the bench. Exposes a `full` flag, frame-alignment error flags and a registered readback port for post-capture dump.

## Interface
- `SAMP_PER_CLK`, 2: complex samples per beat
- `SAMP_WIDTH`, 32: bits per complex sample (16 re + 16 im)
- `FFT_LEN`, 2048: samples per output frame
- `FRAMES`, 32: frames to capture
- Derived: `BEATS = FFT_LEN/SAMP_PER_CLK`, `DEPTH = FRAMES*BEATS`, `AW = $clog2(DEPTH)`
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  arm; rising-level capture request
- `s_axis_tdata`  in  `SAMP_PER_CLK*SAMP_WIDTH`  OSPFB output beat
- `s_axis_tvalid`  in  1
- `s_axis_tlast`  in  1  end of frame
- `s_axis_tready`  out  1
- `full`  out  1  DEPTH beats stored
- `frame_cnt`  out  `$clog2(FRAMES+1)`  completed frames
- `err_tlast_early`  out  1  sticky: tlast before beat BEATS-1
- `err_tlast_missing`  out  1  sticky: no tlast on beat BEATS-1
- `rd_addr`  in  AW  readback address
- `rd_data`  out  `SAMP_PER_CLK*SAMP_WIDTH`  readback data

## Operation
- Accept = `s_axis_tvalid & s_axis_tready`.
- FSM states IDLE, SYNC, CAPTURE, FULL; reset state IDLE.
- IDLE: counters cleared; `en`=1 -> SYNC.
- SYNC: discard beats; accepted beat with tlast=1 -> CAPTURE (first stored beat is the next one, guaranteeing frame alignment).
- CAPTURE: each accept writes tdata to `wr_addr`, increments `wr_addr` and `beat_cnt` (0..BEATS-1, wraps).
  - beat_cnt==BEATS-1 and tlast=0 -> set `err_tlast_missing`; beat_cnt<BEATS-1 and tlast=1 -> set `err_tlast_early`. Counting continues by beat_cnt, never resyncs on tlast.
  - beat_cnt wraps -> `frame_cnt`+1.
  - Accept at `wr_addr`==DEPTH-1 -> FULL.
- FULL: no writes; stays until `en`=0 -> IDLE. Re-arm requires `en` low then high.
- `en`=0 in SYNC or CAPTURE: abort -> IDLE next cycle; counters and flags cleared; RAM contents retained; a simultaneous accept in that cycle is still written.
- Error flags cleared only in IDLE or by reset.
- Readback always enabled, independent of state; read of address being written same cycle returns old data (read-first).

## Timing
- Reset values: `s_axis_tready`=0 (1 without macro), `full`=0, `frame_cnt`=0, both err flags 0, `rd_data`=0, state IDLE.
- `full` rises the cycle after the final accept; `frame_cnt`=FRAMES same cycle.
- `frame_cnt` increments the cycle after the frame's last accept.
- `rd_data` valid one cycle after `rd_addr`.
- IDLE->SYNC one cycle after `en` sampled high; first beat accepted in SYNC may be that cycle+1.
- `s_axis_tready` registered-free: combinational from state only (no dependence on tvalid).

## Configuration
- `OSPFB_CAPTURE_BACKPRESSURE_EN` defined: `s_axis_tready`=1 only in SYNC and CAPTURE; upstream stalls in IDLE/FULL.
- Not defined: `s_axis_tready` tied 1 in all states (incl. reset); beats outside SYNC/CAPTURE are dropped; OSPFB never back-pressured.

## Structure
- In `alpaca_dtypes_pkg`: `capture_state_t` enum (IDLE, SYNC, CAPTURE, FULL) and a `capture_beat_t` packed array type of `SAMP_PER_CLK` complex samples.
- Depth/width constants derive from `alpaca_constants_pkg` `FFT_LEN`, `SAMP_PER_CLK`.
- One sub-module: `capture_sdp_ram` — simple dual-port, one write port, one registered read port, read-first, inferred BRAM.

## Test plan
FFT_LEN=16, SAMP_PER_CLK=2, FRAMES=2 (BEATS=8, DEPTH=16), counter data `tdata`=beat index from 0.
- Arm with 3 junk beats then tlast at index 7, stream 16 more aligned beats -> RAM[0..15]=8..23, `full`=1 cycle after beat 23, `frame_cnt`=2, flags 0.
- Random tvalid gaps (~30%) same stream -> identical RAM contents, `full` timing tied to last accept.
- tlast on captured beat 4 of frame 0 -> `err_tlast_early`=1 and stays; capture still completes 16 beats.
- Drop `en` after 5 captured beats -> IDLE next cycle, `frame_cnt`=0, re-arm captures fresh aligned data starting at RAM[0].
- After FULL, keep tvalid=1: with macro tready=0; without macro tready=1 and RAM unchanged; readback RAM[15] -> 23 one cycle after `rd_addr`=15.
- Assert `rst_n`=0 mid-CAPTURE asynchronously -> all outputs at reset values immediately, state IDLE.
